// File: rtl/tc_io_pkg.sv
// Shared types for the tc_digital_io pad controller.
// Direction states, pull codes and drive width.
package tc_io_pkg;

  localparam int TcIoDriveWidth = 4;

  typedef enum logic [1:0] {
    DIR_IN,
    DIR_TURN_OUT,
    DIR_OUT,
    DIR_TURN_IN
  } tc_io_dir_state_e;

  typedef enum logic [1:0] {
    PULL_NONE = 2'b00,
    PULL_UP   = 2'b01,
    PULL_DOWN = 2'b10
  } tc_io_pull_e;

endpackage

// File: rtl/tc_io_sync_filter.sv
// Pad input synchronizer, optional debounce (TC_IO_CTRL_DEBOUNCE_EN)
// and gated edge pulses. Ports: clk_i, rst_i, pad_i, gate_i ->
// level_o, rise_o, fall_o.
module tc_io_sync_filter #(
  parameter int SyncStages     = 2,
  parameter int DebounceCycles = 4
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic pad_i,
  input  logic gate_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o
);

  logic [SyncStages-1:0] sync_q;
  logic                  synced;
  logic                  level_d;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SyncStages-2:0], pad_i};
    end
  end

  assign synced = sync_q[SyncStages-1];

`ifdef TC_IO_CTRL_DEBOUNCE_EN
  localparam int CntW = $clog2(DebounceCycles + 1);
  localparam logic [CntW-1:0] CntMax = CntW'(DebounceCycles);

  logic [CntW-1:0] cnt_q;

  // Toggle is taken from the held count, so the counter never
  // passes CntMax.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else if (cnt_q == CntMax) begin
      cnt_q <= '0;
    end else if (synced != level_o) begin
      cnt_q <= cnt_q + 1'b1;
    end else begin
      cnt_q <= '0;
    end
  end

  assign level_d = (cnt_q == CntMax) ? ~level_o : level_o;
`else
  logic stage_q;
  logic unused_cfg;

  // Extra stage keeps latency equal to a one-cycle debounce.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      stage_q <= 1'b0;
    end else begin
      stage_q <= synced;
    end
  end

  assign level_d    = stage_q;
  assign unused_cfg = (DebounceCycles > 0);
`endif

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      level_o <= 1'b0;
      rise_o  <= 1'b0;
      fall_o  <= 1'b0;
    end else begin
      level_o <= level_d;
      rise_o  <= gate_i & level_d & ~level_o;
      fall_o  <= gate_i & ~level_d & level_o;
    end
  end

endmodule

// File: rtl/tc_digital_io_ctrl.sv
// Core-side controller for one tc_digital_io pad: direction FSM with
// hi-Z turnaround, output regs, filtered input, edges, sticky irq.
// Optional debounce via TC_IO_CTRL_DEBOUNCE_EN.
module tc_digital_io_ctrl
  import tc_io_pkg::*;
#(
  parameter int SyncStages       = 2,
  parameter int DebounceCycles   = 4,
  parameter int TurnaroundCycles = 2
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      out_en_i,
  input  logic                      out_data_i,
  input  logic [TcIoDriveWidth-1:0] drive_strength_i,
  input  logic [1:0]                pull_i,
  input  logic [1:0]                irq_mask_i,
  input  logic                      irq_clr_i,
  output logic                      in_data_o,
  output logic                      edge_rise_o,
  output logic                      edge_fall_o,
  output logic                      irq_o,
  output logic                      dir_busy_o,
  output logic                      pad_data_o,
  input  logic                      pad_data_i,
  output logic                      pad_oe_no,
  output logic [TcIoDriveWidth-1:0] pad_drive_o,
  output logic                      pad_pullup_en_o,
  output logic                      pad_pulldown_en_o
);

  localparam int TaW = $clog2(TurnaroundCycles + 1);
  localparam logic [TaW-1:0] TaLoad = TaW'(TurnaroundCycles - 1);

  tc_io_dir_state_e state_q;
  logic [TaW-1:0]   cnt_q;
  logic             irq_set;

  // Outputs are registered from the current state, so oe_n and
  // busy change together one edge after the state does.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= DIR_IN;
      cnt_q      <= '0;
      pad_oe_no  <= 1'b1;
      dir_busy_o <= 1'b0;
    end else begin
      pad_oe_no  <= (state_q != DIR_OUT);
      dir_busy_o <= (state_q == DIR_TURN_OUT) |
                    (state_q == DIR_TURN_IN);
      unique case (state_q)
        DIR_IN: begin
          if (out_en_i) begin
            state_q <= DIR_TURN_OUT;
            cnt_q   <= TaLoad;
          end
        end
        DIR_TURN_OUT: begin
          if (!out_en_i) begin
            state_q <= DIR_IN;
          end else if (cnt_q == '0) begin
            state_q <= DIR_OUT;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        DIR_OUT: begin
          if (!out_en_i) begin
            state_q <= DIR_TURN_IN;
            cnt_q   <= TaLoad;
          end
        end
        DIR_TURN_IN: begin
          if (out_en_i) begin
            state_q <= DIR_TURN_OUT;
            cnt_q   <= TaLoad;
          end else if (cnt_q == '0) begin
            state_q <= DIR_IN;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        default: state_q <= DIR_IN;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pad_data_o        <= 1'b0;
      pad_drive_o       <= '0;
      pad_pullup_en_o   <= 1'b0;
      pad_pulldown_en_o <= 1'b0;
    end else begin
      pad_data_o        <= out_data_i;
      pad_drive_o       <= drive_strength_i;
      pad_pullup_en_o   <= (pull_i == PULL_UP);
      pad_pulldown_en_o <= (pull_i == PULL_DOWN);
    end
  end

  tc_io_sync_filter #(
    .SyncStages    (SyncStages),
    .DebounceCycles(DebounceCycles)
  ) u_filter (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .pad_i  (pad_data_i),
    .gate_i (state_q == DIR_IN),
    .level_o(in_data_o),
    .rise_o (edge_rise_o),
    .fall_o (edge_fall_o)
  );

  assign irq_set = (edge_rise_o & irq_mask_i[0]) |
                   (edge_fall_o & irq_mask_i[1]);

  // Set wins over a coincident clear.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      irq_o <= 1'b0;
    end else if (irq_set) begin
      irq_o <= 1'b1;
    end else if (irq_clr_i) begin
      irq_o <= 1'b0;
    end
  end

endmodule

// File: tb/tb_tc_digital_io_ctrl.sv
// Self-checking bench for tc_digital_io_ctrl.
// Directed scenarios plus randomized run against a pad-history model.
module tb_tc_digital_io_ctrl;

  localparam int S = 2;
  localparam int D = 4;
  localparam int T = 2;
`ifdef TC_IO_CTRL_DEBOUNCE_EN
  localparam int L = S + D;
`else
  localparam int L = S + 1;
`endif

  logic       clk_i = 0;
  logic       rst_i = 1;
  logic       out_en_i = 0;
  logic       out_data_i = 0;
  logic [3:0] drive_strength_i = 0;
  logic [1:0] pull_i = 0;
  logic [1:0] irq_mask_i = 0;
  logic       irq_clr_i = 0;
  logic       pad_data_i = 0;
  logic       in_data_o, edge_rise_o, edge_fall_o, irq_o;
  logic       dir_busy_o, pad_data_o, pad_oe_no;
  logic [3:0] pad_drive_o;
  logic       pad_pullup_en_o, pad_pulldown_en_o;

  int errors = 0;
  int checks = 0;

  tc_digital_io_ctrl #(
    .SyncStages      (S),
    .DebounceCycles  (D),
    .TurnaroundCycles(T)
  ) dut (
    .clk_i            (clk_i),
    .rst_i            (rst_i),
    .out_en_i         (out_en_i),
    .out_data_i       (out_data_i),
    .drive_strength_i (drive_strength_i),
    .pull_i           (pull_i),
    .irq_mask_i       (irq_mask_i),
    .irq_clr_i        (irq_clr_i),
    .in_data_o        (in_data_o),
    .edge_rise_o      (edge_rise_o),
    .edge_fall_o      (edge_fall_o),
    .irq_o            (irq_o),
    .dir_busy_o       (dir_busy_o),
    .pad_data_o       (pad_data_o),
    .pad_data_i       (pad_data_i),
    .pad_oe_no        (pad_oe_no),
    .pad_drive_o      (pad_drive_o),
    .pad_pullup_en_o  (pad_pullup_en_o),
    .pad_pulldown_en_o(pad_pulldown_en_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic do_reset();
    rst_i = 1;
    out_en_i = 0;
    pad_data_i = 0;
    irq_clr_i = 0;
    tick();
    tick();
    rst_i = 0;
    tick();
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (pad_oe_no !== 1'b1 || pad_data_o !== 1'b0 ||
        irq_o !== 1'b0 || in_data_o !== 1'b0 ||
        dir_busy_o !== 1'b0 || edge_rise_o !== 1'b0 ||
        edge_fall_o !== 1'b0 || pad_drive_o !== 4'h0 ||
        pad_pullup_en_o !== 1'b0 || pad_pulldown_en_o !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle: oe_n=%b data=%b irq=%b in=%b busy=%b req 1/0/0/0/0",
               pad_oe_no, pad_data_o, irq_o, in_data_o, dir_busy_o);
    end
  endtask

  task automatic test_out_seq();
    logic [3:0] exp_busy;
    logic [3:0] exp_oe;
    exp_busy = 4'b0110;
    exp_oe   = 4'b0111;
    do_reset();
    out_en_i = 1;
    for (int j = 0; j < 4; j++) begin
      tick();
      checks++;
      if (dir_busy_o !== exp_busy[j] || pad_oe_no !== exp_oe[j]) begin
        errors++;
        $display("FAIL out_seq[%0d]: busy=%b oe_n=%b req busy=%b oe_n=%b",
                 j, dir_busy_o, pad_oe_no, exp_busy[j], exp_oe[j]);
      end
    end
  endtask

  task automatic test_reset_in_out();
    out_data_i = 1;
    tick();
    checks++;
    if (pad_oe_no !== 1'b0 || pad_data_o !== 1'b1) begin
      errors++;
      $display("FAIL out_drive: oe_n=%b data=%b req 0/1",
               pad_oe_no, pad_data_o);
    end
    rst_i = 1;
    tick();
    checks++;
    if (pad_oe_no !== 1'b1 || pad_data_o !== 1'b0 ||
        irq_o !== 1'b0 || in_data_o !== 1'b0 || dir_busy_o !== 1'b0) begin
      errors++;
      $display("FAIL reset_in_out: oe_n=%b data=%b irq=%b in=%b busy=%b req 1/0/0/0/0",
               pad_oe_no, pad_data_o, irq_o, in_data_o, dir_busy_o);
    end
    rst_i = 0;
    out_en_i = 0;
    out_data_i = 0;
    tick();
  endtask

  task automatic test_abort();
    int lows;
    do_reset();
    lows = 0;
    out_en_i = 1;
    tick();
    out_en_i = 0;
    for (int j = 0; j < 8; j++) begin
      tick();
      if (pad_oe_no !== 1'b1) lows++;
    end
    checks++;
    if (lows != 0) begin
      errors++;
      $display("FAIL abort_turn_out: oe_n low cycles=%0d req 0", lows);
    end
  endtask

  task automatic test_reenter();
    logic [3:0] exp_oe;
    exp_oe = 4'b0111;
    do_reset();
    out_en_i = 1;
    repeat (5) tick();
    out_en_i = 0;
    tick();
    out_en_i = 1;
    for (int j = 0; j < 4; j++) begin
      tick();
      checks++;
      if (pad_oe_no !== exp_oe[j]) begin
        errors++;
        $display("FAIL reenter[%0d]: oe_n=%b req %b",
                 j, pad_oe_no, exp_oe[j]);
      end
    end
    out_en_i = 0;
    repeat (4) tick();
  endtask

  task automatic test_input_pulse();
    int ins, rises, falls, first_in;
    do_reset();
`ifdef TC_IO_CTRL_DEBOUNCE_EN
    pad_data_i = 1;
    repeat (3) tick();
    pad_data_i = 0;
    ins = 0; rises = 0;
    for (int j = 0; j < 12; j++) begin
      tick();
      ins += int'(in_data_o);
      rises += int'(edge_rise_o);
    end
    checks++;
    if (ins != 0 || rises != 0) begin
      errors++;
      $display("FAIL glitch_reject: in high=%0d rises=%0d req 0/0",
               ins, rises);
    end
    pad_data_i = 1;
    tick();
    first_in = -1; rises = 0;
    for (int j = 1; j <= 10; j++) begin
      tick();
      if (in_data_o === 1'b1 && first_in < 0) first_in = j;
      if (edge_rise_o === 1'b1) begin
        rises++;
        if (j != L) begin
          errors++;
          checks++;
          $display("FAIL rise_time: at %0d req %0d", j, L);
        end
      end
    end
    checks++;
    if (first_in != L || rises != 1) begin
      errors++;
      $display("FAIL debounce_hold: first=%0d rises=%0d req %0d/1",
               first_in, rises, L);
    end
    pad_data_i = 0;
    repeat (12) tick();
`else
    pad_data_i = 1;
    tick();
    pad_data_i = 0;
    ins = 0; rises = 0; falls = 0; first_in = -1;
    for (int j = 1; j <= 8; j++) begin
      tick();
      if (in_data_o === 1'b1) begin
        ins++;
        if (first_in < 0) first_in = j;
      end
      if (edge_rise_o === 1'b1) begin
        rises++;
        checks++;
        if (j != L) begin
          errors++;
          $display("FAIL rise_time: at %0d req %0d", j, L);
        end
      end
      if (edge_fall_o === 1'b1) begin
        falls++;
        checks++;
        if (j != L + 1) begin
          errors++;
          $display("FAIL fall_time: at %0d req %0d", j, L + 1);
        end
      end
    end
    checks++;
    if (ins != 1 || first_in != L || rises != 1 || falls != 1) begin
      errors++;
      $display("FAIL single_pulse: high=%0d first=%0d r=%0d f=%0d req 1/%0d/1/1",
               ins, first_in, rises, falls, L);
    end
`endif
  endtask

  task automatic test_irq();
    int c;
    do_reset();
    irq_mask_i = 2'b10;
    pad_data_i = 1;
    c = 0;
    while (edge_rise_o !== 1'b1 && c < 30) begin
      tick();
      c++;
    end
    checks++;
    if (edge_rise_o !== 1'b1) begin
      errors++;
      $display("FAIL irq_rise_wait: no rise pulse in %0d cycles", c);
    end
    tick();
    tick();
    checks++;
    if (irq_o !== 1'b0) begin
      errors++;
      $display("FAIL irq_masked_rise: irq=%b req 0", irq_o);
    end
    pad_data_i = 0;
    c = 0;
    while (edge_fall_o !== 1'b1 && c < 30) begin
      tick();
      c++;
    end
    checks++;
    if (edge_fall_o !== 1'b1 || irq_o !== 1'b0) begin
      errors++;
      $display("FAIL irq_fall_pulse: fall=%b irq=%b req 1/0",
               edge_fall_o, irq_o);
    end
    tick();
    checks++;
    if (irq_o !== 1'b1) begin
      errors++;
      $display("FAIL irq_after_fall: irq=%b req 1", irq_o);
    end
    pad_data_i = 1;
    repeat (L + 4) tick();
    pad_data_i = 0;
    c = 0;
    while (edge_fall_o !== 1'b1 && c < 30) begin
      tick();
      c++;
    end
    irq_clr_i = 1;
    tick();
    checks++;
    if (irq_o !== 1'b1) begin
      errors++;
      $display("FAIL irq_set_wins: irq=%b req 1", irq_o);
    end
    tick();
    irq_clr_i = 0;
    checks++;
    if (irq_o !== 1'b0) begin
      errors++;
      $display("FAIL irq_clear: irq=%b req 0", irq_o);
    end
    irq_mask_i = 2'b00;
  endtask

  task automatic test_edge_mask();
    int pulses;
    do_reset();
    out_en_i = 1;
    repeat (6) tick();
    pulses = 0;
    for (int k = 0; k < 4; k++) begin
      pad_data_i = ~k[0];
      for (int j = 0; j < L + 3; j++) begin
        tick();
        pulses += int'(edge_rise_o) + int'(edge_fall_o);
      end
      checks++;
      if (in_data_o !== pad_data_i) begin
        errors++;
        $display("FAIL out_track[%0d]: in=%b req %b",
                 k, in_data_o, pad_data_i);
      end
    end
    checks++;
    if (pulses != 0) begin
      errors++;
      $display("FAIL edge_mask: pulses=%0d req 0", pulses);
    end
    out_en_i = 0;
    repeat (6) tick();
  endtask

  task automatic test_random();
    logic hist[$];
    logic exp_in, prev_in, exp_r, exp_f, exp_irq, tog;
    logic e_data, e_pu, e_pd;
    logic [3:0] e_drv;
    int n, hold, last_t, bad;
    do_reset();
    hist.delete();
    for (int i = 0; i < 16; i++) hist.push_back(1'b0);
    exp_in = 0; exp_r = 0; exp_f = 0; exp_irq = 0;
    last_t = -100;
    hold = 0;
    bad = 0;
    for (int i = 0; i < 500; i++) begin
      if (hold == 0) begin
        pad_data_i = ($urandom_range(0, 1) == 1);
        hold = $urandom_range(1, 7);
      end
      hold--;
      irq_mask_i = 2'($urandom_range(0, 3));
      irq_clr_i = ($urandom_range(0, 3) == 0);
      out_data_i = ($urandom_range(0, 1) == 1);
      drive_strength_i = 4'($urandom_range(0, 15));
      pull_i = 2'($urandom_range(0, 3));
      hist.push_back(pad_data_i);
      n = hist.size() - 1;
      exp_irq = (exp_r & irq_mask_i[0]) | (exp_f & irq_mask_i[1]) |
                (exp_irq & ~irq_clr_i);
      e_data = out_data_i;
      e_drv = drive_strength_i;
      e_pu = (pull_i == 2'b01);
      e_pd = (pull_i == 2'b10);
      prev_in = exp_in;
`ifdef TC_IO_CTRL_DEBOUNCE_EN
      tog = (n - last_t > D);
      for (int k = 0; k < D; k++)
        if (hist[n - D - S + k] == exp_in) tog = 0;
      if (tog) begin
        exp_in = ~exp_in;
        last_t = n;
      end
`else
      tog = 0;
      exp_in = hist[n - S - 1];
`endif
      exp_r = exp_in & ~prev_in;
      exp_f = ~exp_in & prev_in;
      tick();
      checks++;
      if (in_data_o !== exp_in || edge_rise_o !== exp_r ||
          edge_fall_o !== exp_f || irq_o !== exp_irq) begin
        errors++;
        if (bad < 10)
          $display("FAIL rand_in[%0d]: in=%b r=%b f=%b irq=%b req %b/%b/%b/%b",
                   i, in_data_o, edge_rise_o, edge_fall_o, irq_o,
                   exp_in, exp_r, exp_f, exp_irq);
        bad++;
      end
      checks++;
      if (pad_data_o !== e_data || pad_drive_o !== e_drv ||
          pad_pullup_en_o !== e_pu || pad_pulldown_en_o !== e_pd) begin
        errors++;
        if (bad < 10)
          $display("FAIL rand_out[%0d]: d=%b drv=%h pu=%b pd=%b req %b/%h/%b/%b",
                   i, pad_data_o, pad_drive_o, pad_pullup_en_o,
                   pad_pulldown_en_o, e_data, e_drv, e_pu, e_pd);
        bad++;
      end
    end
  endtask

  initial begin
    test_reset();
    test_out_seq();
    test_reset_in_out();
    test_abort();
    test_reenter();
    test_input_pulse();
    test_irq();
    test_edge_mask();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
